// File: rtl/muldiv_ctrl_if.sv
// Request/response bundle between decode, muldiv_ctrl and register writeback.
// Handshake: start_i is a request taken only while busy_o=0 and flush_i=0;
// valid_o is a one-cycle result strobe with no back-pressure, and stall_o
// holds the pipeline from the request cycle until the result cycle.
interface muldiv_ctrl_if #(
    parameter int RDATA_WIDTH = 32,
    parameter int RADDR_WIDTH = 5
);
    logic                   start_i;
    logic [2:0]             funct3_i;
    logic [RDATA_WIDTH-1:0] op1_i;
    logic [RDATA_WIDTH-1:0] op2_i;
    logic [RADDR_WIDTH-1:0] waddr_i;
    logic                   flush_i;
    logic                   busy_o;
    logic                   stall_o;
    logic                   valid_o;
    logic [RDATA_WIDTH-1:0] result_o;
    logic                   reg_we_o;
    logic [RADDR_WIDTH-1:0] reg_waddr_o;

    modport master (
        output start_i, funct3_i, op1_i, op2_i, waddr_i, flush_i,
        input  busy_o, stall_o, valid_o, result_o, reg_we_o, reg_waddr_o
    );

    modport slave (
        input  start_i, funct3_i, op1_i, op2_i, waddr_i, flush_i,
        output busy_o, stall_o, valid_o, result_o, reg_we_o, reg_waddr_o
    );
endinterface

// File: rtl/muldiv_ctrl.sv
// RV32 M-extension sequencer: single-cycle (or iterative) multiply, 32-cycle restoring divide.
// Define MULDIV_ITER_MUL_EN for a 32-cycle shift-add multiplier instead of a hardware multiplier.
module muldiv_ctrl (
    input  logic               clk,
    input  logic               rst,
    muldiv_ctrl_if.slave       bus,
    output logic [1:0]         dbg_state_o
);
    localparam int RADDR_WIDTH = 5;

    typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_e;

    state_e                 state_q;
    logic [5:0]             cnt_q;
    logic [1:0]             f3_q;
    logic [RADDR_WIDTH-1:0] rd_q;
    logic                   neg_q;
    logic [31:0]            mag_b_q;
    logic [63:0]            acc_q;
    logic [31:0]            result_q;
`ifndef MULDIV_ITER_MUL_EN
    logic [31:0]            op_a_q;
    logic [31:0]            op_b_q;
`endif

    function automatic logic sgn_a(input logic [2:0] f);
        return f[2] ? ~f[0] : (f[1:0] != 2'b11);
    endfunction

    function automatic logic sgn_b(input logic [2:0] f);
        return f[2] ? ~f[0] : ~f[1];
    endfunction

    logic        a_neg, b_neg, neg_d, div_zero, div_ovf;
    logic [31:0] a_mag, b_mag, special_res;

    always_comb begin
        a_neg       = sgn_a(bus.funct3_i) & bus.op1_i[31];
        b_neg       = sgn_b(bus.funct3_i) & bus.op2_i[31];
        a_mag       = a_neg ? -bus.op1_i : bus.op1_i;
        b_mag       = b_neg ? -bus.op2_i : bus.op2_i;
        // Remainder follows the dividend sign; quotient and product follow the sign xor.
        neg_d       = (bus.funct3_i[2] & bus.funct3_i[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero    = (bus.op2_i == 32'd0);
        div_ovf     = ~bus.funct3_i[0] && (bus.op1_i == 32'h8000_0000) && (bus.op2_i == 32'hFFFF_FFFF);
        special_res = div_zero ? (bus.funct3_i[1] ? bus.op1_i : 32'hFFFF_FFFF)
                               : (bus.funct3_i[1] ? 32'd0 : 32'h8000_0000);
    end

    // Restoring divide step: acc_q holds {remainder, dividend bits still to shift in}.
    logic [32:0] div_r;
    logic        div_ge;
    logic [63:0] div_next;
    logic [31:0] div_pick, div_res;

    always_comb begin
        div_r    = {acc_q[63:32], acc_q[31]};
        div_ge   = (div_r >= {1'b0, mag_b_q});
        div_next = {(div_ge ? div_r[31:0] - mag_b_q : div_r[31:0]), acc_q[30:0], div_ge};
        div_pick = f3_q[1] ? div_next[63:32] : div_next[31:0];
        div_res  = neg_q ? -div_pick : div_pick;
    end

    logic [63:0] mul_prod;
    logic [31:0] mul_res;
`ifdef MULDIV_ITER_MUL_EN
    logic [32:0] mul_sum;
    logic [63:0] mul_next;

    // Shift-add: acc_q = {partial product high, remaining multiplier bits}.
    always_comb begin
        mul_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, mag_b_q} : 33'd0);
        mul_next = {mul_sum, acc_q[31:1]};
        mul_prod = neg_q ? -mul_next : mul_next;
        mul_res  = (f3_q == 2'b00) ? mul_prod[31:0] : mul_prod[63:32];
    end
`else
    logic [63:0] mul_a, mul_b;

    // Sign-extended operands give the 33x33 signed product modulo 2^64.
    always_comb begin
        mul_a    = {{32{sgn_a({1'b0, f3_q}) & op_a_q[31]}}, op_a_q};
        mul_b    = {{32{sgn_b({1'b0, f3_q}) & op_b_q[31]}}, op_b_q};
        mul_prod = mul_a * mul_b;
        mul_res  = (f3_q == 2'b00) ? mul_prod[31:0] : mul_prod[63:32];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= 6'd0;
            f3_q     <= 2'd0;
            rd_q     <= '0;
            neg_q    <= 1'b0;
            mag_b_q  <= 32'd0;
            acc_q    <= 64'd0;
            result_q <= 32'd0;
`ifndef MULDIV_ITER_MUL_EN
            op_a_q   <= 32'd0;
            op_b_q   <= 32'd0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_i && !bus.flush_i) begin
                        f3_q    <= bus.funct3_i[1:0];
                        rd_q    <= bus.waddr_i;
                        neg_q   <= neg_d;
                        mag_b_q <= b_mag;
                        acc_q   <= {32'd0, a_mag};
                        cnt_q   <= 6'd0;
`ifndef MULDIV_ITER_MUL_EN
                        op_a_q  <= bus.op1_i;
                        op_b_q  <= bus.op2_i;
`endif
                        if (!bus.funct3_i[2]) begin
                            state_q <= MUL;
                        end else if (div_zero || div_ovf) begin
                            state_q  <= DONE;
                            result_q <= special_res;
                        end else begin
                            state_q <= DIV;
                        end
                    end
                end
                MUL: begin
                    if (bus.flush_i) begin
                        state_q <= IDLE;
                    end else begin
`ifdef MULDIV_ITER_MUL_EN
                        acc_q <= mul_next;
                        cnt_q <= cnt_q + 6'd1;
                        if (cnt_q == 6'd31) begin
                            result_q <= mul_res;
                            state_q  <= DONE;
                        end
`else
                        result_q <= mul_res;
                        state_q  <= DONE;
`endif
                    end
                end
                DIV: begin
                    if (bus.flush_i) begin
                        state_q <= IDLE;
                    end else begin
                        acc_q <= div_next;
                        cnt_q <= cnt_q + 6'd1;
                        if (cnt_q == 6'd31) begin
                            result_q <= div_res;
                            state_q  <= DONE;
                        end
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    logic done_ok;
    assign done_ok         = (state_q == DONE) && !bus.flush_i && !rst;
    assign bus.busy_o      = (state_q != IDLE) && !rst;
    assign bus.stall_o     = !rst && (((state_q == IDLE) && bus.start_i) || (state_q == MUL) || (state_q == DIV));
    assign bus.valid_o     = done_ok;
    assign bus.reg_we_o    = done_ok;
    assign bus.result_o    = done_ok ? result_q : 32'd0;
    assign bus.reg_waddr_o = done_ok ? rd_q : '0;
    assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl (default and MULDIV_ITER_MUL_EN builds).
module tb_muldiv_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] dbg_state;
    int         n_checks = 0;
    int         n_errors = 0;

`ifdef MULDIV_ITER_MUL_EN
    localparam int MUL_LAT = 33;
`else
    localparam int MUL_LAT = 2;
`endif

    typedef struct packed {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    always #5 clk = ~clk;

    muldiv_ctrl_if bus ();

    muldiv_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic s, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] rd);
        bus.start_i  = s;
        bus.funct3_i = f3;
        bus.op1_i    = a;
        bus.op2_i    = b;
        bus.waddr_i  = rd;
    endtask

    // Issues one op and waits for its strobe; lat=-1 if it never arrives.
    task automatic issue_and_wait(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                                  input logic [4:0] rd, output int lat, output logic [31:0] res,
                                  output logic we, output logic [4:0] wa, output int stall_bad);
        lat = -1; res = '0; we = 1'b0; wa = '0; stall_bad = 0;
        next_cycle();
        drive_req(1'b1, f3, a, b, rd);
        @(negedge clk);
        if (bus.stall_o !== 1'b1) stall_bad++;
        next_cycle();
        bus.start_i = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (bus.valid_o === 1'b1) begin
                lat = c; res = bus.result_o; we = bus.reg_we_o; wa = bus.reg_waddr_o;
                if (bus.stall_o !== 1'b0) stall_bad++;
                break;
            end
            if (bus.stall_o !== 1'b1 || bus.result_o !== 32'd0 || bus.reg_we_o !== 1'b0) stall_bad++;
            next_cycle();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.flush_i = 1'b1;
        drive_req(1'b1, 3'b100, 32'd9, 32'd3, 5'd4);
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (bus.busy_o !== 1'b0) begin n_errors++; $display("FAIL rst_busy got=%b exp=0", bus.busy_o); end
        n_checks++; if (bus.stall_o !== 1'b0) begin n_errors++; $display("FAIL rst_stall got=%b exp=0", bus.stall_o); end
        n_checks++; if (bus.valid_o !== 1'b0) begin n_errors++; $display("FAIL rst_valid got=%b exp=0", bus.valid_o); end
        n_checks++; if (bus.result_o !== 32'd0) begin n_errors++; $display("FAIL rst_result got=%h exp=0", bus.result_o); end
        n_checks++; if ({bus.reg_we_o, bus.reg_waddr_o} !== 6'd0) begin n_errors++; $display("FAIL rst_wb got=%b exp=0", {bus.reg_we_o, bus.reg_waddr_o}); end
        next_cycle();
        rst = 1'b0;
        bus.flush_i = 1'b0;
        drive_req(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
        @(negedge clk);
        n_checks++; if (bus.busy_o !== 1'b0 || bus.stall_o !== 1'b0) begin n_errors++; $display("FAIL post_rst_idle got busy=%b stall=%b exp 0 0", bus.busy_o, bus.stall_o); end
        n_checks++; if (dbg_state !== 2'd0) begin n_errors++; $display("FAIL post_rst_state got=%0d exp=0", dbg_state); end
    endtask

    task automatic run_table(input vec_t v, input string tag);
        int lat, sb; logic [31:0] res; logic we; logic [4:0] wa;
        issue_and_wait(v.f3, v.a, v.b, v.rd, lat, res, we, wa, sb);
        n_checks++; if (lat != v.lat) begin n_errors++; $display("FAIL %s_lat f3=%b got=%0d exp=%0d", tag, v.f3, lat, v.lat); end
        n_checks++; if (res !== v.exp) begin n_errors++; $display("FAIL %s_result f3=%b a=%h b=%h got=%h exp=%h", tag, v.f3, v.a, v.b, res, v.exp); end
        n_checks++; if (we !== 1'b1 || wa !== v.rd) begin n_errors++; $display("FAIL %s_wb got we=%b rd=%0d exp we=1 rd=%0d", tag, we, wa, v.rd); end
        n_checks++; if (sb != 0) begin n_errors++; $display("FAIL %s_stall bad_cycles got=%0d exp=0", tag, sb); end
    endtask

    task automatic test_mul();
        vec_t t[6];
        t[0] = '{3'b000, 32'd7,          32'hFFFF_FFFD, 5'd3,  32'hFFFF_FFEB, MUL_LAT};
        t[1] = '{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'hFFFF_FFFE, MUL_LAT};
        t[2] = '{3'b010, 32'hFFFF_FFFF, 32'd2,         5'd9,  32'hFFFF_FFFF, MUL_LAT};
        t[3] = '{3'b001, 32'h8000_0000, 32'h8000_0000, 5'd31, 32'h4000_0000, MUL_LAT};
        t[4] = '{3'b001, 32'd7,          32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFFF, MUL_LAT};
        t[5] = '{3'b000, 32'h1234_5678, 32'h0000_0010, 5'd0,  32'h2345_6780, MUL_LAT};
        for (int i = 0; i < 6; i++) run_table(t[i], "mul");
    endtask

    task automatic test_div();
        vec_t t[12];
        t[0]  = '{3'b100, 32'hFFFF_FFF9, 32'd2,         5'd1,  32'hFFFF_FFFD, 33};
        t[1]  = '{3'b110, 32'hFFFF_FFF9, 32'd2,         5'd2,  32'hFFFF_FFFF, 33};
        t[2]  = '{3'b101, 32'd100,       32'd7,         5'd3,  32'd14,        33};
        t[3]  = '{3'b111, 32'd100,       32'd7,         5'd4,  32'd2,         33};
        t[4]  = '{3'b100, 32'd7,         32'hFFFF_FFFE, 5'd5,  32'hFFFF_FFFD, 33};
        t[5]  = '{3'b110, 32'd7,         32'hFFFF_FFFE, 5'd6,  32'd1,         33};
        t[6]  = '{3'b101, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'd1,         33};
        t[7]  = '{3'b111, 32'hDEAD_BEEF, 32'h0001_0000, 5'd12, 32'h0000_BEEF, 33};
        t[8]  = '{3'b101, 32'd5,         32'd0,         5'd8,  32'hFFFF_FFFF, 1};
        t[9]  = '{3'b110, 32'd5,         32'd0,         5'd9,  32'd5,         1};
        t[10] = '{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'h8000_0000, 1};
        t[11] = '{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0,         1};
        for (int i = 0; i < 12; i++) run_table(t[i], "div");
    endtask

    task automatic test_flush();
        int early = 0; int lat = -1; logic [31:0] res = '0; int seen = 0;
        // Flush a divide in cycle 10, restart in cycle 11, expect result in cycle 44.
        next_cycle();
        drive_req(1'b1, 3'b100, 32'd1000, 32'd3, 5'd12);
        for (int c = 1; c <= 10; c++) begin
            next_cycle();
            bus.start_i = 1'b0;
            if (c == 10) bus.flush_i = 1'b1;
            @(negedge clk);
            if (bus.valid_o === 1'b1) early++;
        end
        n_checks++; if (bus.busy_o !== 1'b1) begin n_errors++; $display("FAIL flush_busy_c10 got=%b exp=1", bus.busy_o); end
        next_cycle();
        bus.flush_i = 1'b0;
        drive_req(1'b1, 3'b101, 32'd100, 32'd7, 5'd13);
        @(negedge clk);
        n_checks++; if (bus.busy_o !== 1'b0 || dbg_state !== 2'd0) begin n_errors++; $display("FAIL flush_idle_c11 got busy=%b state=%0d exp 0 0", bus.busy_o, dbg_state); end
        for (int c = 12; c <= 70; c++) begin
            next_cycle();
            bus.start_i = 1'b0;
            @(negedge clk);
            if (bus.valid_o === 1'b1) begin lat = c; res = bus.result_o; break; end
        end
        n_checks++; if (early != 0) begin n_errors++; $display("FAIL flush_no_valid got=%0d exp=0", early); end
        n_checks++; if (lat != 44) begin n_errors++; $display("FAIL flush_restart_lat got=%0d exp=44", lat); end
        n_checks++; if (res !== 32'd14) begin n_errors++; $display("FAIL flush_restart_result got=%h exp=0000000e", res); end

        // Flush together with start: request dropped.
        next_cycle();
        drive_req(1'b1, 3'b000, 32'd3, 32'd3, 5'd2);
        bus.flush_i = 1'b1;
        next_cycle();
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.busy_o !== 1'b0) begin n_errors++; $display("FAIL flush_with_start_busy got=%b exp=0", bus.busy_o); end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.valid_o === 1'b1) seen++;
        end
        n_checks++; if (seen != 0) begin n_errors++; $display("FAIL flush_with_start_valid got=%0d exp=0", seen); end

        // Flush in the DONE cycle suppresses the strobe.
        next_cycle();
        drive_req(1'b1, 3'b000, 32'd7, 32'hFFFF_FFFD, 5'd3);
        for (int c = 1; c <= MUL_LAT; c++) begin
            next_cycle();
            bus.start_i = 1'b0;
        end
        bus.flush_i = 1'b1;
        @(negedge clk);
        n_checks++; if (dbg_state !== 2'd3) begin n_errors++; $display("FAIL flush_done_state got=%0d exp=3", dbg_state); end
        n_checks++; if ({bus.valid_o, bus.reg_we_o} !== 2'b00 || bus.result_o !== 32'd0) begin n_errors++; $display("FAIL flush_done_suppress got valid=%b we=%b res=%h exp 0 0 0", bus.valid_o, bus.reg_we_o, bus.result_o); end
        next_cycle();
        bus.flush_i = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.busy_o !== 1'b0) begin n_errors++; $display("FAIL flush_done_idle got=%b exp=0", bus.busy_o); end
    endtask

    task automatic test_hold_start();
        int early = 0; logic v33; logic [31:0] r33; logic s33;
        next_cycle();
        drive_req(1'b1, 3'b100, 32'hFFFF_FFF9, 32'd2, 5'd14);
        for (int c = 1; c <= 33; c++) begin
            next_cycle();
            drive_req(1'b1, 3'b000, 32'h5555_0000 + c, 32'd3, 5'd20);
            @(negedge clk);
            if (c < 33 && bus.valid_o === 1'b1) early++;
        end
        v33 = bus.valid_o; r33 = bus.result_o; s33 = bus.stall_o;
        n_checks++; if (early != 0) begin n_errors++; $display("FAIL hold_early_valid got=%0d exp=0", early); end
        n_checks++; if (v33 !== 1'b1 || r33 !== 32'hFFFF_FFFD) begin n_errors++; $display("FAIL hold_result got valid=%b res=%h exp 1 fffffffd", v33, r33); end
        n_checks++; if (s33 !== 1'b0) begin n_errors++; $display("FAIL hold_done_stall got=%b exp=0", s33); end
        next_cycle();
        bus.start_i = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.busy_o !== 1'b0) begin n_errors++; $display("FAIL hold_not_accepted got busy=%b exp=0", bus.busy_o); end
    endtask

    task automatic test_rst_mid();
        int seen = 0;
        next_cycle();
        drive_req(1'b1, 3'b101, 32'd100, 32'd7, 5'd15);
        for (int c = 1; c <= 5; c++) begin
            next_cycle();
            bus.start_i = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if ({bus.busy_o, bus.stall_o, bus.valid_o, bus.reg_we_o, bus.reg_waddr_o, bus.result_o} !== 41'd0) begin
            n_errors++;
            $display("FAIL rst_mid_outputs got busy=%b stall=%b valid=%b we=%b rd=%0d res=%h exp all 0",
                     bus.busy_o, bus.stall_o, bus.valid_o, bus.reg_we_o, bus.reg_waddr_o, bus.result_o);
        end
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.busy_o !== 1'b0) begin n_errors++; $display("FAIL rst_mid_idle got=%b exp=0", bus.busy_o); end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (bus.valid_o === 1'b1) seen++;
        end
        n_checks++; if (seen != 0) begin n_errors++; $display("FAIL rst_mid_valid got=%0d exp=0", seen); end
    endtask

    initial begin
        rst = 1'b1;
        bus.flush_i = 1'b0;
        drive_req(1'b0, 3'b000, 32'd0, 32'd0, 5'd0);
        test_reset();
        test_mul();
        test_div();
        test_flush();
        test_hold_start();
        test_rst_mid();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 Single clock; reset is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start_i  input  1  M-extension op request from decode (opcode INST_TYPE_R_M, funct7=0000001).
REQ-005 funct3_i  input  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-006 op1_i / op2_i  input  RDATA_WIDTH (32)  rs1 / rs2 operand values.
REQ-007 waddr_i  input  RADDR_WIDTH  destination register rd.
REQ-008 flush_i  input  1  pipeline flush; aborts any op in progress.
REQ-009 busy_o  output  1  high whenever state != IDLE.
REQ-010 stall_o  output  1  pipeline hold request.
REQ-011 valid_o  output  1  one-cycle result strobe.
REQ-012 result_o  output  RDATA_WIDTH  result, meaningful only while valid_o=1, else 0.
REQ-013 reg_we_o / reg_waddr_o  output  1 / RADDR_WIDTH  writeback enable/address; equal valid_o / latched rd, else WRITE_DISABLE / ZERO_REG.

Function
REQ-014 FSM states IDLE, MUL, DIV, DONE; cycle 0 = cycle with start_i=1 in IDLE.
REQ-015 start_i sampled only in IDLE; ignored in MUL, DIV, DONE; operands, funct3, rd latched at the accepting edge.
REQ-016 IDLE->MUL for funct3[2]=0; MUL lasts one cycle (cycle 1); DONE in cycle 2.
REQ-017 IDLE->DIV for funct3[2]=1 with normal operands; 32-iteration restoring divide on magnitudes, one quotient bit per cycle (cycles 1..32); 6-bit iteration counter; DONE in cycle 33.
REQ-018 Divide special cases bypass DIV: IDLE->DONE, result in cycle 1.
REQ-019 Divide by zero: DIV/DIVU quotient 0xFFFFFFFF; REM/REMU remainder = op1.
REQ-020 Signed overflow (op1=0x80000000, op2=0xFFFFFFFF, DIV/REM): quotient 0x80000000, remainder 0.
REQ-021 Signed divide: quotient negated when operand signs differ; remainder takes sign of dividend.
REQ-022 MUL returns low 32 bits of 64-bit product; MULH signed x signed, MULHSU signed op1 x unsigned op2, MULHU unsigned x unsigned return high 32 bits.
REQ-023 DONE lasts exactly one cycle: valid_o=1, reg_we_o=1, then ->IDLE.
REQ-024 stall_o = (IDLE and start_i) or state in {MUL, DIV}; stall_o=0 in DONE so pipeline advances with the result.
REQ-025 flush_i in any state: next state IDLE, no valid_o; flush_i same cycle as start_i: request not accepted; flush_i in DONE suppresses valid_o and reg_we_o that cycle.
REQ-026 rd = x0 still completes normally; reg_waddr_o=0 with reg_we_o=1 (register file discards).

Reset
REQ-027 rst: state IDLE, counter 0, internal operand/result registers 0.
REQ-028 While rst=1 and the cycle after: busy_o=0, stall_o=0 (unless start_i on post-reset cycle), valid_o=0, result_o=0, reg_we_o=0, reg_waddr_o=0.
REQ-029 rst mid-operation discards the op; no valid_o issued for it.
REQ-030 rst has priority over flush_i and start_i.

Configuration
REQ-031 Macro MULDIV_ITER_MUL_EN selects multiplier implementation.
REQ-032 Defined: MUL is 32-cycle shift-add on magnitudes with sign fix-up (cycles 1..32), DONE in cycle 33; no hardware multiplier inferred.
REQ-033 Undefined: single-cycle combinational 33x33 signed product in MUL (REQ-016 latency); divider unaffected either way.

Verification
REQ-034 MUL 7 x 0xFFFFFFFD (-3) -> valid_o cycle 2, result 0xFFFFFFEB, reg_we_o=1, reg_waddr_o=rd; stall_o high cycles 0-1 only.
REQ-035 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
REQ-036 DIV 0xFFFFFFF9 (-7) / 2 -> cycle 33, 0xFFFFFFFD; REM same operands -> 0xFFFFFFFF; DIVU 100/7 -> 14, REMU -> 2.
REQ-037 DIVU 5/0 -> cycle 1, 0xFFFFFFFF; REM 5/0 -> 5; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-038 DIV started, flush_i at cycle 10 -> IDLE cycle 11, busy_o=0, no valid_o; new start_i cycle 11 accepted and completes cycle 44.
REQ-039 start_i held high during DIV and DONE -> ignored; rst at cycle 5 of DIV -> all outputs 0, no valid_o; repeat REQ-034 with MULDIV_ITER_MUL_EN defined -> valid_o cycle 33, same result.
